// File: rtl/led_bank_arbiter.sv
// Shares a 4-LED bank between heartbeat (0), debug (1) and error (2) sources.
// Error preempts, 0/1 alternate round-robin with a minimum hold, and every handover is blanked.
module led_bank_arbiter #(
   parameter int TICK_DIV  = 100_000,
   parameter int MIN_HOLD  = 250,
   parameter int GAP_TICKS = 50
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [2:0]  req,
   input  logic [11:0] pat,
   input  logic [3:0]  bright,
   output logic [2:0]  gnt,
   output logic [3:0]  led,
   output logic        busy
);

   localparam int TW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
   localparam int HW = (MIN_HOLD > 0) ? $clog2(MIN_HOLD + 1) : 1;
   localparam int GW = (GAP_TICKS > 0) ? $clog2(GAP_TICKS + 1) : 1;

   localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
   localparam logic [HW-1:0] HOLD_INIT = HW'(MIN_HOLD);
   localparam logic [GW-1:0] GAP_INIT  = GW'(GAP_TICKS);
   localparam logic [3:0]    PWM_LAST  = 4'd14;

   typedef enum logic [1:0] {
      S_IDLE,
      S_OWN,
      S_GAP
   } state_t;

   state_t        state, state_n;
   logic [TW-1:0] tick_cnt;
   logic          tick;
   logic [3:0]    pwm_cnt;
   logic          pwm_on;
   logic [HW-1:0] hold_cnt, hold_n;
   logic [GW-1:0] gap_cnt, gap_n;
   logic [1:0]    owner, owner_n;
   logic          rr_last, rr_n;
   logic [2:0]    gnt_n;
   logic [3:0]    led_n;

   logic [1:0]    win;
   logic [3:0]    owner_pat;
   logic [2:0]    own_mask;
   logic          other_req;
   logic          do_grant;
   logic          leave;

   // ---------------------------------------------------------------- timebase
   assign tick = (tick_cnt == TICK_LAST);

   // NOTE: sequential state is assigned with <= so every flop samples the pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         tick_cnt <= '0;
      end else if (tick) begin
         tick_cnt <= '0;
      end else begin
         tick_cnt <= tick_cnt + 1'b1;
      end
   end

   // 15-clk PWM period makes bright=15 fully on and bright=0 fully off.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pwm_cnt <= '0;
      end else if (pwm_cnt == PWM_LAST) begin
         pwm_cnt <= '0;
      end else begin
         pwm_cnt <= pwm_cnt + 1'b1;
      end
   end

   assign pwm_on = (pwm_cnt < bright);

   // ------------------------------------------------------------- arbitration
   always_comb begin
      win = 2'd0;
      if (req[2]) begin
         win = 2'd2;
      end else if (req[1] && req[0]) begin
         win = rr_last ? 2'd0 : 2'd1;
      end else if (req[1]) begin
         win = 2'd1;
      end
   end

   always_comb begin
      owner_pat = 4'h0;
      case (owner)
         2'd0:    owner_pat = pat[3:0];
         2'd1:    owner_pat = pat[7:4];
         2'd2:    owner_pat = pat[11:8];
         default: owner_pat = 4'h0;
      endcase
   end

   assign own_mask  = 3'b001 << owner;
   assign other_req = (owner == 2'd0) ? req[1] : req[0];

   // ---------------------------------------------------------- next state
   // NOTE: every output of this block gets a default first, so no path can infer a latch.
   always_comb begin
      state_n  = state;
      gnt_n    = gnt;
      led_n    = led;
      hold_n   = hold_cnt;
      gap_n    = gap_cnt;
      owner_n  = owner;
      rr_n     = rr_last;
      do_grant = 1'b0;
      leave    = 1'b0;

      case (state)
         S_IDLE: begin
            gnt_n    = 3'b000;
            led_n    = 4'h0;
            do_grant = |req;
         end

         S_OWN: begin
            if (!req[owner]) begin
               leave   = 1'b1;
               state_n = |(req & ~own_mask) ? S_GAP : S_IDLE;
            end else if (owner != 2'd2 && req[2]) begin
               leave   = 1'b1;
               state_n = S_GAP;
            end else if (hold_cnt == '0 && owner != 2'd2 && other_req) begin
               leave   = 1'b1;
               state_n = S_GAP;
            end else begin
               led_n = owner_pat & {4{pwm_on}};
               if (tick && hold_cnt != '0) begin
                  hold_n = hold_cnt - 1'b1;
               end
            end

            if (leave) begin
               gnt_n = 3'b000;
               led_n = 4'h0;
               gap_n = GAP_INIT;
            end
         end

         S_GAP: begin
            gnt_n = 3'b000;
            led_n = 4'h0;
            if (gap_cnt == '0) begin
               if (|req) begin
                  do_grant = 1'b1;
               end else begin
                  state_n = S_IDLE;
               end
            end else if (tick) begin
               gap_n = gap_cnt - 1'b1;
            end
         end

         default: begin
            state_n = S_IDLE;
            gnt_n   = 3'b000;
            led_n   = 4'h0;
         end
      endcase

      // A fresh grant always restarts the hold time and blanks the LEDs for one clk.
      if (do_grant) begin
         state_n = S_OWN;
         owner_n = win;
         gnt_n   = 3'b001 << win;
         led_n   = 4'h0;
         hold_n  = HOLD_INIT;
         if (!win[1]) begin
            rr_n = win[0];
         end
      end
   end

   // NOTE: every control flop is reset, so the bank goes dark the instant rst rises.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= S_IDLE;
         gnt      <= 3'b000;
         led      <= 4'h0;
         hold_cnt <= '0;
         gap_cnt  <= '0;
         owner    <= 2'd0;
         rr_last  <= 1'b1;
      end else begin
         state    <= state_n;
         gnt      <= gnt_n;
         led      <= led_n;
         hold_cnt <= hold_n;
         gap_cnt  <= gap_n;
         owner    <= owner_n;
         rr_last  <= rr_n;
      end
   end

   assign busy = (state != S_IDLE);

endmodule

// File: tb/tb_led_bank_arbiter.sv
// Bench for led_bank_arbiter: two instances (gap of 2 ticks and 1-clk gap) checked every cycle
// against a tick/phase model, plus directed literal expectations for each scenario.
module tb_led_bank_arbiter;

   localparam int TD = 4;
   localparam int MH = 3;
   localparam int GT = 2;

   logic        clk;
   logic        rst;
   logic [2:0]  req;
   logic [11:0] pat;
   logic [3:0]  bright;
   logic [2:0]  gnt_a, gnt_b;
   logic [3:0]  led_a, led_b;
   logic        busy_a, busy_b;

   int checks = 0;
   int errors = 0;

   led_bank_arbiter #(.TICK_DIV(TD), .MIN_HOLD(MH), .GAP_TICKS(GT)) dut_a (
      .clk(clk), .rst(rst), .req(req), .pat(pat), .bright(bright),
      .gnt(gnt_a), .led(led_a), .busy(busy_a)
   );

   led_bank_arbiter #(.TICK_DIV(TD), .MIN_HOLD(MH), .GAP_TICKS(0)) dut_b (
      .clk(clk), .rst(rst), .req(req), .pat(pat), .bright(bright),
      .gnt(gnt_b), .led(led_b), .busy(busy_b)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
      end
   endtask

   // ------------------------------------------------------------------ model
   // phase: 0 idle, 1 owned, 2 blank gap; timers counted in whole ticks.
   typedef struct {
      int         phase;
      int         owner;
      int         hold;
      int         gap;
      int         rr;
      logic [2:0] gnt;
      logic [3:0] led;
   } model_t;

   localparam model_t MODEL_RESET = '{phase: 0, owner: 0, hold: 0, gap: 0, rr: 1,
                                      gnt: 3'b000, led: 4'h0};

   function automatic model_t step(input model_t m, input int gap_ticks, input logic [2:0] r,
                                   input logic [11:0] p, input logic [3:0] b, input int e);
      model_t n;
      bit     tick;
      bit     lit;
      bit     grant;
      int     o;
      int     other;
      int     w;
      n     = m;
      tick  = (e % TD) == TD - 1;
      lit   = (e % 15) < int'(b);
      grant = 0;
      o     = m.owner;
      other = (o == 0) ? 1 : 0;
      n.gnt = 3'b000;
      n.led = 4'h0;
      if (m.phase == 0) begin
         grant = (r != 3'b000);
      end else if (m.phase == 1) begin
         if (!r[o]) begin
            n.phase = ((r & ~(3'b001 << o)) != 3'b000) ? 2 : 0;
            n.gap   = gap_ticks;
         end else if (o != 2 && r[2]) begin
            n.phase = 2;
            n.gap   = gap_ticks;
         end else if (o != 2 && m.hold == 0 && r[other]) begin
            n.phase = 2;
            n.gap   = gap_ticks;
         end else begin
            n.gnt = m.gnt;
            n.led = lit ? p[4*o +: 4] : 4'h0;
            if (tick && m.hold > 0) n.hold = m.hold - 1;
         end
      end else begin
         if (m.gap == 0) begin
            if (r != 3'b000) grant = 1;
            else             n.phase = 0;
         end else if (tick) begin
            n.gap = m.gap - 1;
         end
      end
      if (grant) begin
         if (r[2])              w = 2;
         else if (r[1] && r[0]) w = (m.rr == 0) ? 1 : 0;
         else                   w = r[1] ? 1 : 0;
         n.phase = 1;
         n.owner = w;
         n.gnt   = 3'b001 << w;
         n.hold  = MH;
         if (w < 2) n.rr = w;
      end
      return n;
   endfunction

   model_t ma, mb;
   int     edge_no;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         ma      = MODEL_RESET;
         mb      = MODEL_RESET;
         edge_no = 0;
      end else begin
         ma      = step(ma, GT, req, pat, bright, edge_no);
         mb      = step(mb, 0, req, pat, bright, edge_no);
         edge_no = edge_no + 1;
      end
   end

   always @(negedge clk) begin
      if (!rst) begin
         check("a_gnt", gnt_a, ma.gnt);
         check("a_led", led_a, ma.led);
         check("a_busy", busy_a, ma.phase != 0);
         check("b_gnt", gnt_b, mb.gnt);
         check("b_led", led_b, mb.led);
         check("b_busy", busy_b, mb.phase != 0);
      end
   end

   // --------------------------------------------------------------- helpers
   task automatic tick_clk(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      req = 3'b000;
      tick_clk(2);
      rst = 1'b0;
   endtask

   task automatic wait_gnt_a(input logic [2:0] want, input int budget, input string name);
      int n;
      n = 0;
      while (gnt_a !== want && n < budget) begin
         tick_clk(1);
         n++;
      end
      check(name, gnt_a, want);
   endtask

   logic [2:0] seq_a[$], seq_b[$];
   int         runs_a[$], runs_b[$];

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   // ---------------------------------------------------------------- stimulus
   initial begin
      logic [2:0] prev_a, prev_b;
      int         zr_a, zr_b, cnt;

      rst    = 1'b1;
      req    = 3'b000;
      pat    = 12'h000;
      bright = 4'd15;
      tick_clk(2);
      check("rst_gnt", gnt_a, 3'b000);
      check("rst_led", led_a, 4'h0);
      check("rst_busy", busy_a, 1'b0);
      rst = 1'b0;

      // Async reset in the middle of ownership.
      pat = 12'h00A;
      req = 3'b001;
      tick_clk(1);
      check("first_gnt", gnt_a, 3'b001);
      tick_clk(1);
      check("first_led", led_a, 4'hA);
      tick_clk(2);
      #3 rst = 1'b1;
      #1;
      check("async_gnt", gnt_a, 3'b000);
      check("async_led", led_a, 4'h0);
      check("async_busy", busy_a, 1'b0);
      req = 3'b000;
      tick_clk(1);
      rst = 1'b0;
      pat = 12'h005;
      req = 3'b001;
      tick_clk(1);
      check("post_rst_gnt", gnt_a, 3'b001);
      tick_clk(1);
      check("post_rst_led", led_a, 4'h5);

      // Round robin 0 -> 1 -> 0 with blank gaps.
      do_reset();
      pat = 12'h021;
      req = 3'b011;
      prev_a = 3'b000; prev_b = 3'b000; zr_a = 0; zr_b = 0;
      for (int c = 0; c < 120; c++) begin
         tick_clk(1);
         if (gnt_a == 3'b000) zr_a++;
         else begin
            if (prev_a == 3'b000) begin
               if (seq_a.size() > 0) runs_a.push_back(zr_a);
               seq_a.push_back(gnt_a);
            end
            zr_a = 0;
         end
         if (gnt_b == 3'b000) zr_b++;
         else begin
            if (prev_b == 3'b000) begin
               if (seq_b.size() > 0) runs_b.push_back(zr_b);
               seq_b.push_back(gnt_b);
            end
            zr_b = 0;
         end
         prev_a = gnt_a;
         prev_b = gnt_b;
      end
      check("rr_a_grants", seq_a.size() >= 3, 1'b1);
      if (seq_a.size() >= 3) begin
         check("rr_a_0", seq_a[0], 3'b001);
         check("rr_a_1", seq_a[1], 3'b010);
         check("rr_a_2", seq_a[2], 3'b001);
         check("rr_a_gap", runs_a[0] >= 6 && runs_a[0] <= 9, 1'b1);
      end
      check("rr_b_grants", seq_b.size() >= 3, 1'b1);
      if (seq_b.size() >= 3) begin
         check("rr_b_0", seq_b[0], 3'b001);
         check("rr_b_1", seq_b[1], 3'b010);
         check("rr_b_2", seq_b[2], 3'b001);
         check("gap0_run0", runs_b[0], 1);
         check("gap0_run1", runs_b[1], 1);
      end

      // Error source preempts a fresh owner and then keeps the bank.
      do_reset();
      pat = 12'h301;
      req = 3'b001;
      tick_clk(1);
      check("pre_own", gnt_a, 3'b001);
      tick_clk(2);
      req = 3'b101;
      tick_clk(1);
      check("preempt_gnt0", gnt_a, 3'b000);
      check("preempt_led0", led_a, 4'h0);
      wait_gnt_a(3'b100, 20, "preempt_gnt2");
      cnt = 0;
      for (int c = 0; c < 30; c++) begin
         tick_clk(1);
         if (gnt_a == 3'b100) cnt++;
      end
      check("err_keeps", cnt, 30);
      req = 3'b001;
      tick_clk(1);
      check("err_release", gnt_a, 3'b000);
      wait_gnt_a(3'b001, 20, "back_to_0");

      // Sole owner release goes straight to idle.
      do_reset();
      pat = 12'h070;
      req = 3'b010;
      tick_clk(1);
      check("rel_gnt", gnt_a, 3'b010);
      tick_clk(3);
      req = 3'b000;
      tick_clk(1);
      check("rel_gnt0", gnt_a, 3'b000);
      check("rel_led0", led_a, 4'h0);
      check("rel_busy0", busy_a, 1'b0);

      // PWM duty over one full 15-clk window.
      pat    = 12'h0F0;
      req    = 3'b010;
      bright = 4'd4;
      tick_clk(3);
      cnt = 0;
      for (int c = 0; c < 15; c++) begin
         tick_clk(1);
         if (led_a == 4'hF) cnt++;
      end
      check("pwm_4", cnt, 4);
      bright = 4'd0;
      tick_clk(2);
      cnt = 0;
      for (int c = 0; c < 15; c++) begin
         tick_clk(1);
         if (led_a == 4'hF) cnt++;
      end
      check("pwm_0", cnt, 0);
      bright = 4'd15;
      tick_clk(2);
      cnt = 0;
      for (int c = 0; c < 15; c++) begin
         tick_clk(1);
         if (led_a == 4'hF) cnt++;
      end
      check("pwm_15", cnt, 15);
      req = 3'b000;
      tick_clk(3);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
